// File: rtl/fib_stream_checker_pkg.sv
// Shared definitions for the Fibonacci stream checker: FSM state codes and default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// State encodings match the generator's, so both sides decode the same values.
package fib_stream_checker_pkg;

  localparam int FIB_W      = 4;  // sample width, matches the generator output
  localparam int FIB_LOCK_N = 4;  // consecutive good checks before reporting lock
  localparam int FIB_CNT_W  = 8;  // saturating error counter width
  localparam int PERIOD_W   = 8;  // measured period / pair counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    CHECK = 2'd2
  } fib_state_t;

endpackage

// File: rtl/fib_stream_checker_period_counter.sv
// Measures the recurrence period: counts matched pairs from the lock-time seed pair until it recurs.
// Latency: period/period_valid update one clock after the sample that closes the cycle.
// Backpressure: none; only acts on the qualified strobes it is given.
// Ports: clock, reset (async, active-high); track = matched sample while already locked;
//        miss = mismatched sample; lock_rise = match that raises locked;
//        pair_a/pair_b = sample pair after this match; period, period_valid = result.
// Compiled only when PERIOD_MEASURE_EN is defined; the default build has no pair counter.
`ifdef PERIOD_MEASURE_EN
module fib_stream_checker_period_counter
  import fib_stream_checker_pkg::*;
#(
  parameter int W = FIB_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                track,
  input  logic                miss,
  input  logic                lock_rise,
  input  logic [W-1:0]        pair_a,
  input  logic [W-1:0]        pair_b,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  logic [W-1:0]        seed_a;
  logic [W-1:0]        seed_b;
  logic [PERIOD_W-1:0] pair_cnt;
  logic [PERIOD_W-1:0] pair_inc;

  // Saturating increment; a stream that never repeats parks at all-ones.
  assign pair_inc = (pair_cnt == '1) ? pair_cnt : pair_cnt + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seed_a       <= '0;
      seed_b       <= '0;
      pair_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (miss) begin
      // period keeps its last measurement; only the valid flag drops
      period_valid <= 1'b0;
    end else if (lock_rise) begin
      seed_a   <= pair_a;
      seed_b   <= pair_b;
      pair_cnt <= '0;
    end else if (track) begin
      if (pair_a == seed_a && pair_b == seed_b) begin
        period       <= pair_inc;
        period_valid <= 1'b1;
        pair_cnt     <= '0;
      end else begin
        pair_cnt <= pair_inc;
      end
    end
  end

endmodule
`endif

// File: rtl/fib_stream_checker.sv
// Checks a Fibonacci sample stream against x[n]=x[n-1]+x[n-2] mod 2^W; flags errors, counts them, reports lock.
// Latency: all outputs registered, visible the cycle after the sampling edge.
// Backpressure: none; valid_in=0 holds all state and forces err low.
// Ports: clock; reset (async, active-high); valid_in/entrada = incoming sample;
//        locked, err (1-cycle pulse), err_count (saturating), period/period_valid.
// Optional: `define PERIOD_MEASURE_EN adds period measurement; otherwise period=0, period_valid=0.
module fib_stream_checker
  import fib_stream_checker_pkg::*;
#(
  parameter int W      = FIB_W,
  parameter int LOCK_N = FIB_LOCK_N,
  parameter int CNT_W  = FIB_CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [W-1:0]        entrada,
  output logic                locked,
  output logic                err,
  output logic [CNT_W-1:0]    err_count,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  localparam int                 MATCH_W  = $clog2(LOCK_N + 1);
  localparam logic [MATCH_W-1:0] LOCK_MAX = MATCH_W'(LOCK_N);

  fib_state_t         state, state_nxt;
  logic [W-1:0]       a, a_nxt;
  logic [W-1:0]       b, b_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic               locked_nxt;
  logic               err_nxt;
  logic [CNT_W-1:0]   err_count_nxt;
  logic [W-1:0]       exp_val;
  logic               hit;
  logic               miss;

  // Carry out of the W-bit add is dropped: the generator wraps mod 2^W.
  assign exp_val = a + b;
  assign hit     = valid_in && (state == CHECK) && (entrada == exp_val);
  assign miss    = valid_in && (state == CHECK) && (entrada != exp_val);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      match_cnt <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      match_cnt <= match_nxt;
      locked    <= locked_nxt;
      err       <= err_nxt;
      err_count <= err_count_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    a_nxt         = a;
    b_nxt         = b;
    match_nxt     = match_cnt;
    locked_nxt    = locked;
    err_nxt       = 1'b0;
    err_count_nxt = err_count;
    if (valid_in) begin
      case (state)
        IDLE: begin
          a_nxt     = entrada;
          state_nxt = PRIME;
        end
        PRIME: begin
          b_nxt     = entrada;
          state_nxt = CHECK;
        end
        CHECK: begin
          if (hit) begin
            a_nxt = b;
            b_nxt = entrada;
            if (match_cnt != LOCK_MAX) match_nxt = match_cnt + 1'b1;
            if (match_nxt == LOCK_MAX) locked_nxt = 1'b1;
          end else begin
            // Resync on the bad sample itself: it becomes the new a.
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
            match_nxt  = '0;
            a_nxt      = entrada;
            state_nxt  = PRIME;
            if (err_count != '1) err_count_nxt = err_count + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef PERIOD_MEASURE_EN
  logic lock_rise;
  assign lock_rise = hit & ~locked & locked_nxt;

  // Pair after this match is (b, entrada), the same pair a/b will hold next cycle.
  fib_stream_checker_period_counter #(.W(W)) u_period (
    .clock        (clock),
    .reset        (reset),
    .track        (hit & locked),
    .miss         (miss),
    .lock_rise    (lock_rise),
    .pair_a       (b),
    .pair_b       (entrada),
    .period       (period),
    .period_valid (period_valid)
  );
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fib_stream_checker.sv
module tb_fib_stream_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic [3:0] entrada = 4'd0;
  logic       locked, err;
  logic [7:0] err_count;
  logic [7:0] period;
  logic       period_valid;

  // Second instance with a 2-bit error counter for the saturation case.
  logic       valid2 = 1'b0;
  logic [3:0] ent2 = 4'd0;
  logic       locked2, err2;
  logic [1:0] cnt2;
  logic [7:0] period2;
  logic       pv2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  fib_stream_checker dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .entrada(entrada),
    .locked(locked), .err(err), .err_count(err_count),
    .period(period), .period_valid(period_valid)
  );

  fib_stream_checker #(.W(4), .LOCK_N(4), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .valid_in(valid2), .entrada(ent2),
    .locked(locked2), .err(err2), .err_count(cnt2),
    .period(period2), .period_valid(pv2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one input for one edge, then sample 1 time unit after that edge.
  task automatic step(input logic v, input logic [3:0] d);
    valid_in = v;
    entrada  = d;
    @(posedge clock);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic v, input logic [3:0] d,
                          input logic lk, input logic er);
    step(v, d);
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".err"}, 32'(err), 32'(er));
  endtask

  task automatic apply_reset();
    valid_in = 1'b0;
    valid2   = 1'b0;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int seq[6] = '{1, 2, 3, 5, 8, 13};
    int s4[11] = '{0, 0, 1, 0, 2, 0, 3, 0, 4, 0, 5};
    int pulses;
    logic [3:0] xp, xc, xn;

    // ---- reset state ----
    repeat (2) @(posedge clock);
    #1;
    chk("rst.locked", 32'(locked), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.err_count", 32'(err_count), 0);
    chk("rst.period", 32'(period), 0);
    chk("rst.period_valid", 32'(period_valid), 0);
    chk("rst.cnt2", 32'(cnt2), 0);
    reset = 1'b0;

    // ---- test 1: clean stream locks after 13 ----
    for (int i = 0; i < 6; i++) step_chk("t1", 1'b1, 4'(seq[i]), (i == 5), 1'b0);
    chk("t1.err_count", 32'(err_count), 0);

    // ---- test 2: 8 corrupted to 9, resync, relock after 4 good samples ----
    apply_reset();
    step_chk("t2", 1'b1, 4'd1, 1'b0, 1'b0);
    step_chk("t2", 1'b1, 4'd2, 1'b0, 1'b0);
    step_chk("t2", 1'b1, 4'd3, 1'b0, 1'b0);
    step_chk("t2", 1'b1, 4'd5, 1'b0, 1'b0);
    step_chk("t2.bad", 1'b1, 4'd9, 1'b0, 1'b1);
    chk("t2.err_count", 32'(err_count), 1);
    step_chk("t2.prime", 1'b1, 4'd13, 1'b0, 1'b0);
    step_chk("t2", 1'b1, 4'd6, 1'b0, 1'b0);   // 9+13=22 mod 16
    step_chk("t2", 1'b1, 4'd3, 1'b0, 1'b0);   // 13+6=19 mod 16
    step_chk("t2", 1'b1, 4'd9, 1'b0, 1'b0);
    step_chk("t2.relock", 1'b1, 4'd12, 1'b1, 1'b0);
    chk("t2.err_count_end", 32'(err_count), 1);

    // ---- test 3: same stream with 3-cycle gaps of garbage data ----
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step_chk("t3", 1'b1, 4'(seq[i]), (i == 5), 1'b0);
      for (int g = 0; g < 3; g++) step_chk("t3.gap", 1'b0, 4'hF, (i == 5), 1'b0);
    end
    chk("t3.err_count", 32'(err_count), 0);
    step_chk("t3.bad", 1'b1, 4'd0, 1'b0, 1'b1);  // expected 8+13=21 -> 5
    step_chk("t3.gap_err", 1'b0, 4'd5, 1'b0, 1'b0);
    chk("t3.err_count_end", 32'(err_count), 1);

    // ---- test 4: CNT_W=2, five mismatches, counter saturates at 3 ----
    apply_reset();
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      valid2 = 1'b1;
      ent2   = 4'(s4[i]);
      @(posedge clock);
      #1;
      chk("t4.err", 32'(err2), 32'((i >= 2) && (i % 2 == 0)));
      if (err2) pulses++;
      if (i == 6) chk("t4.cnt_at3", 32'(cnt2), 3);
    end
    valid2 = 1'b0;
    chk("t4.pulses", pulses, 5);
    chk("t4.cnt_sat", 32'(cnt2), 3);
    chk("t4.locked", 32'(locked2), 0);

    // ---- test 5: reset while locked, then replay relocks ----
    apply_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 4'(seq[i]));
    step_chk("t5.bad", 1'b1, 4'd7, 1'b0, 1'b1);
    step(1'b1, 4'd1);
    step(1'b1, 4'd8);
    step(1'b1, 4'd9);
    step(1'b1, 4'd1);
    step_chk("t5.lock", 1'b1, 4'd10, 1'b1, 1'b0);
    chk("t5.err_count_pre", 32'(err_count), 1);
    reset = 1'b1;
    step(1'b1, 4'd3);
    chk("t5.rst.locked", 32'(locked), 0);
    chk("t5.rst.err", 32'(err), 0);
    chk("t5.rst.err_count", 32'(err_count), 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step_chk("t5.replay", 1'b1, 4'(seq[i]), (i == 5), 1'b0);

    // ---- test 6: free-running generator, mod-16 Pisano period 24 ----
    apply_reset();
    xp = 4'd1;
    xc = 4'd2;
    step(1'b1, xp);
    step(1'b1, xc);
    for (int i = 0; i < 4; i++) begin
      xn = xp + xc;
      step(1'b1, xn);
      xp = xc;
      xc = xn;
    end
    chk("t6.locked", 32'(locked), 1);
    for (int i = 1; i <= 24; i++) begin
      xn = xp + xc;
      step(1'b1, xn);
      xp = xc;
      xc = xn;
      chk("t6.err", 32'(err), 0);
`ifdef PERIOD_MEASURE_EN
      if (i == 23) chk("t6.pv_early", 32'(period_valid), 0);
`endif
    end
`ifdef PERIOD_MEASURE_EN
    chk("t6.period", 32'(period), 24);
    chk("t6.period_valid", 32'(period_valid), 1);
    step_chk("t6.bad", 1'b1, 4'(xp + xc + 4'd1), 1'b0, 1'b1);
    chk("t6.pv_cleared", 32'(period_valid), 0);
    chk("t6.period_kept", 32'(period), 24);
`else
    chk("t6.period", 32'(period), 0);
    chk("t6.period_valid", 32'(period_valid), 0);
`endif
    chk("t6.err_count", 32'(err_count), 0);

    valid_in = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
